// File: rtl/pll_pkg.sv
// Shared PLL definitions: FCW clamp helpers and the guard-bit constant used
// when sign-extending tuning words into the wide raw FCW sum.
package pll_pkg;

    // One extra bit keeps the centre + scaled-ctrl sum from overflowing.
    localparam int SEXT_GUARD = 1;

    // Width of the signed raw FCW sum for a given accumulator/ctrl/gain set.
    function automatic int raw_width(input int accW, input int ctrlW, input int gainShift);
        return accW + ctrlW + gainShift + SEXT_GUARD;
    endfunction

    // Clamp a signed raw FCW into [lo, hi].
    function automatic longint fcw_clamp(input longint raw, input longint lo, input longint hi);
        if (raw < lo) begin
            return lo;
        end
        if (raw > hi) begin
            return hi;
        end
        return raw;
    endfunction

    // True when the raw FCW lies outside [lo, hi] and would be clamped.
    function automatic logic fcw_out_of_range(input longint raw, input longint lo, input longint hi);
        return (raw < lo) || (raw > hi);
    endfunction

endpackage

// File: rtl/vco_nco_if.sv
// Tuning/observation bundle of the NCO: loop-filter side drives the controls,
// the oscillator drives the registered outputs.
interface vco_nco_if #(
    parameter int ACC_W  = 16,
    parameter int CTRL_W = 8
) ();

    logic              en;
    logic              hold;
    logic [CTRL_W-1:0] ctrl;
    logic              ctrl_valid;
    logic              vco_out;
    logic [ACC_W-1:0]  phase;
    logic [ACC_W-1:0]  fcw;
    logic              wrap;
    logic              sat;

    modport master (
        output en, hold, ctrl, ctrl_valid,
        input  vco_out, phase, fcw, wrap, sat
    );

    modport slave (
        input  en, hold, ctrl, ctrl_valid,
        output vco_out, phase, fcw, wrap, sat
    );

endinterface

// File: rtl/vco_nco_phase_acc.sv
// Phase accumulator: adds the FCW each enabled cycle, flags the carry-out as
// a one-cycle wrap pulse and registers the new MSB as the square-wave output.
module phase_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_fcw,
    output logic [ACC_W-1:0] o_phase,
    output logic             o_carry,
    output logic             o_msb
);

    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] r_phase;
    logic             r_carry;
    logic             r_msb;

    assign w_sum = {1'b0, r_phase} + {1'b0, i_fcw};

    // Advance the phase when enabled; when disabled keep the phase but force
    // the output and the wrap marker low so the divider sees a quiet line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_carry <= 1'b0;
            r_msb   <= 1'b0;
        end else if (i_en) begin
            r_phase <= w_sum[ACC_W-1:0];
            r_carry <= w_sum[ACC_W];
            r_msb   <= w_sum[ACC_W-1];
        end else begin
            r_carry <= 1'b0;
            r_msb   <= 1'b0;
        end
    end

    assign o_phase = r_phase;
    assign o_carry = r_carry;
    assign o_msb   = r_msb;

endmodule

// File: rtl/vco_nco.sv
// Numerically controlled oscillator for the PLL loop. The signed tuning word
// from the loop filter is scaled, offset by the centre FCW and clamped into
// a legal FCW that drives a phase accumulator.
module vco_nco
    import pll_pkg::*;
#(
    parameter int ACC_W      = 16,
    parameter int CTRL_W     = 8,
    parameter int GAIN_SHIFT = 0,
    parameter int CENTER_FCW = 2**(ACC_W-3),
    parameter int FCW_MIN    = 1,
    parameter int FCW_MAX    = 2**(ACC_W-1) - 1
) (
    input  logic     clk,
    input  logic     rst,
    vco_nco_if.slave bus
);

    localparam int RAW_W = raw_width(ACC_W, CTRL_W, GAIN_SHIFT);

    // FCW above half range would allow two wraps per output period.
    if (ACC_W < 4 || FCW_MIN < 1 || FCW_MIN > FCW_MAX || FCW_MAX >= 2**(ACC_W-1)) begin : g_badParams
        $error("vco_nco: illegal FCW parameters (need 1 <= FCW_MIN <= FCW_MAX < 2**(ACC_W-1), ACC_W >= 4)");
    end

    logic signed [RAW_W-1:0] w_ctrlExt;
    logic signed [RAW_W-1:0] w_raw;
    logic                    w_sat;
    logic                    w_update;
    logic [ACC_W-1:0]        r_fcw;
    logic                    r_sat;

    assign w_ctrlExt = RAW_W'($signed(bus.ctrl));
    assign w_raw     = RAW_W'(CENTER_FCW) + (w_ctrlExt <<< GAIN_SHIFT);
    assign w_sat     = fcw_out_of_range(longint'(w_raw), longint'(FCW_MIN), longint'(FCW_MAX));
    assign w_update  = bus.ctrl_valid && !bus.hold;

    // Latch a new clamped FCW on accepted tuning words; hold drops the word
    // outright and the saturation flag sticks until the next accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcw <= ACC_W'(CENTER_FCW);
            r_sat <= 1'b0;
        end else if (w_update) begin
            r_fcw <= ACC_W'(fcw_clamp(longint'(w_raw), longint'(FCW_MIN), longint'(FCW_MAX)));
            r_sat <= w_sat;
        end
    end

    logic [ACC_W-1:0] w_phase;
    logic             w_wrap;
    logic             w_vcoOut;

    phase_acc #(
        .ACC_W (ACC_W)
    ) u_phaseAcc (
        .clk     (clk),
        .rst     (rst),
        .i_en    (bus.en),
        .i_fcw   (r_fcw),
        .o_phase (w_phase),
        .o_carry (w_wrap),
        .o_msb   (w_vcoOut)
    );

    assign bus.phase   = w_phase;
    assign bus.wrap    = w_wrap;
    assign bus.vco_out = w_vcoOut;
    assign bus.fcw     = r_fcw;
    assign bus.sat     = r_sat;

endmodule

// File: tb/tb_vco_nco.sv
// Directed bench for vco_nco with ACC_W=8, CENTER_FCW=32, clamp [8, 96].
module tb_vco_nco;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    vco_nco_if #(.ACC_W(8), .CTRL_W(8)) bus ();

    vco_nco #(
        .ACC_W      (8),
        .CTRL_W     (8),
        .GAIN_SHIFT (0),
        .CENTER_FCW (32),
        .FCW_MIN    (8),
        .FCW_MAX    (96)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected sequence completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Set the inputs, let one rising edge pass, sample 1 ns after it.
    task automatic applyStimulus(input logic iRst, input logic iEn, input logic iHold,
                                 input logic [7:0] iCtrl, input logic iValid);
        rst            = iRst;
        bus.en         = iEn;
        bus.hold       = iHold;
        bus.ctrl       = iCtrl;
        bus.ctrl_valid = iValid;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAcc(input string tag, input int expPhase, input int expVco, input int expWrap);
        checkOutput({tag, ".phase"},   32'(bus.phase),   32'(expPhase));
        checkOutput({tag, ".vco_out"}, 32'(bus.vco_out), 32'(expVco));
        checkOutput({tag, ".wrap"},    32'(bus.wrap),    32'(expWrap));
    endtask

    task automatic checkFcw(input string tag, input int expFcw, input int expSat);
        checkOutput({tag, ".fcw"}, 32'(bus.fcw), 32'(expFcw));
        checkOutput({tag, ".sat"}, 32'(bus.sat), 32'(expSat));
    endtask

    int runPhase [8] = '{32, 64, 96, 128, 160, 192, 224, 0};
    int runVco   [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int runWrap  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        // Reset with noisy controls: reset must dominate.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd16, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        checkAcc("reset", 0, 0, 0);
        checkFcw("reset", 32, 0);

        // Free run at the centre FCW: one full period of 8 steps.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
            checkAcc($sformatf("run%0d", i), runPhase[i], runVco[i], runWrap[i]);
        end
        checkFcw("run", 32, 0);

        // Walk up to phase 160, then disable for five cycles.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        end
        checkAcc("preGate", 160, 1, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            checkAcc($sformatf("gated%0d", i), 160, 0, 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        checkAcc("reEnable", 192, 1, 0);

        // In-range tune +16: this edge still steps by 32, next by 48.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd16, 1'b1);
        checkFcw("tunePlus16", 48, 0);
        checkAcc("tunePlus16", 224, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd16, 1'b0);
        checkAcc("step48", 16, 0, 1);

        // In-range tune -8.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'(-8), 1'b1);
        checkFcw("tuneMinus8", 24, 0);
        checkAcc("tuneMinus8", 64, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        checkAcc("step24", 88, 0, 0);

        // Saturation high, low, and back to centre.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd100, 1'b1);
        checkFcw("satHigh", 96, 1);
        checkAcc("satHigh", 112, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'(-50), 1'b1);
        checkFcw("satLow", 8, 1);
        checkAcc("satLow", 208, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        checkFcw("centre", 32, 0);
        checkAcc("centre", 216, 1, 0);

        // Hold drops a concurrent update; releasing hold does not replay it.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd40, 1'b1);
        checkFcw("holdDrop", 32, 0);
        checkAcc("holdDrop", 248, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd40, 1'b0);
        checkFcw("holdRelease", 32, 0);
        checkAcc("holdRelease", 24, 0, 1);

        // Exact clamp boundaries are legal and do not flag saturation.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd64, 1'b1);
        checkFcw("edgeMax", 96, 0);
        checkAcc("edgeMax", 56, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'(-24), 1'b1);
        checkFcw("edgeMin", 8, 0);
        checkAcc("edgeMin", 152, 1, 0);

        // Saturate again, run, then reset mid-period with a valid word pending.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd100, 1'b1);
        checkFcw("preReset", 96, 1);
        checkAcc("preReset", 160, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        checkAcc("preResetWrap", 0, 0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        checkAcc("preResetRun", 96, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd16, 1'b1);
        checkAcc("midReset", 0, 0, 0);
        checkFcw("midReset", 32, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        checkAcc("afterReset", 32, 0, 0);
        checkFcw("afterReset", 32, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
